// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int ITERATIONS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div_op(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on a shared 64-bit accumulator, result delivered to the rd write port.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// CALC  | 32 iterations, then one sign-fix edge that loads result
// DONE  | one-cycle done / write pulse, start ignored
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            write_enable_rd,
  output logic [4:0]      address_rd
);

  muldiv_state_e   state, next_state;
  muldiv_op_e      op, op_in;
  logic [4:0]      count;
  logic            fixup;
  logic [63:0]     acc;
  logic [31:0]     opb;
  logic            neg_q, neg_r;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [31:0]     a_mag, b_mag;
  logic            div_zero, div_ovf, special;

  logic [32:0]     mul_sum;
  logic [63:0]     mul_next;
  logic [64:0]     div_shift;
  logic [32:0]     div_trial;
  logic [63:0]     div_next;
  logic [63:0]     prod;
  logic [31:0]     quot, rem;
  logic [31:0]     result_next;

  always_comb begin
    op_in    = muldiv_op_e'(funct3);
    a_signed = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_in inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = a_signed & operand_a[31];
    b_neg    = b_signed & operand_b[31];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
    div_zero = is_div_op(op_in) && (operand_b == '0);
    div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
               (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    special  = div_zero || div_ovf;
  end

  // Multiply: a magnitude sits in the low half as multiplier, b is the multiplicand.
  // Divide: low half holds the dividend shifting into the partial remainder above it.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc, 1'b0};
    div_trial = div_shift[64:32] - {1'b0, opb};
    div_next  = div_trial[32] ? div_shift[63:0]
                              : {div_trial[31:0], div_shift[31:1], 1'b1};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[31:0] : acc[31:0];
    rem  = neg_r ? -acc[63:32] : acc[63:32];
    result_next = '0;
    unique case (op)
      OP_MUL:                       result_next = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_next = prod[63:32];
      OP_DIV, OP_DIVU:              result_next = quot;
      OP_REM, OP_REMU:              result_next = rem;
      default:                      result_next = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (fixup) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op         <= OP_MUL;
      count      <= '0;
      fixup      <= 1'b0;
      acc        <= '0;
      opb        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result     <= '0;
      address_rd <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          op         <= op_in;
          address_rd <= rd_in;
          count      <= 5'(ITERATIONS - 1);
          opb        <= b_mag;
          // Special-case divides skip the iterations and go straight to the fix-up edge.
          fixup      <= special;
          if (div_zero) begin
            acc   <= {operand_a, 32'hFFFF_FFFF};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else if (div_ovf) begin
            acc   <= {32'h0, 32'h8000_0000};
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            acc   <= {32'h0, a_mag};
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        CALC: begin
          if (fixup) begin
            result <= result_next;
            fixup  <= 1'b0;
          end else begin
            acc   <= is_div_op(op) ? div_next : mul_next;
            count <= count - 5'd1;
            if (count == 5'd0) fixup <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state == CALC);
  assign done            = (state == DONE);
  assign write_enable_rd = done && (address_rd != 5'd0);

endmodule
